// File: rtl/async_fifo_lvl.sv
// Dual-clock FIFO with gray-coded pointer crossing, fill levels on both sides,
// programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Read data is show-ahead: rd_data always presents the head entry while empty is low.
module async_fifo_lvl #(
  parameter int unsigned W        = 8,
  parameter int unsigned AW       = 2,
  parameter int unsigned SYNC_STG = 2
) (
  // Write domain
  input  logic          wr_clk,
  input  logic          wr_reset_n,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic [AW:0]   wr_afull_th,
  input  logic          ovf_clr,
  output logic          full,
  output logic          afull,
  output logic [AW:0]   wr_level,
  output logic          overflow,
  // Read domain
  input  logic          rd_clk,
  input  logic          rd_reset_n,
  input  logic          rd_en,
  input  logic [AW:0]   rd_aempty_th,
  input  logic          udf_clr,
  output logic [W-1:0]  rd_data,
  output logic          empty,
  output logic          aempty,
  output logic [AW:0]   rd_level,
  output logic          underflow
);

  localparam int unsigned DP       = 2 ** AW;
  // Level value meaning "completely full": only the extra MSB set.
  localparam logic [AW:0] LvlFull  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] PtrOne   = {{AW{1'b0}}, 1'b1};

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR of all higher gray bits recovers the binary value.
  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b = g;
    for (int unsigned i = 1; i <= AW; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  // Storage (not reset)
  logic [W-1:0] r_mem [DP];

  // Write-domain state
  logic [AW:0] r_wr_bin;
  logic [AW:0] r_wr_gray;
  logic        r_overflow;
  logic [AW:0] r_rd_gray_sync [SYNC_STG];

  // Read-domain state
  logic [AW:0] r_rd_bin;
  logic [AW:0] r_rd_gray;
  logic        r_underflow;
  logic [AW:0] r_wr_gray_sync [SYNC_STG];

  // Combinational helpers
  logic        w_wr_push;
  logic [AW:0] w_wr_bin_nxt;
  logic [AW:0] w_rd_bin_sync;
  logic        w_rd_pop;
  logic [AW:0] w_rd_bin_nxt;
  logic [AW:0] w_wr_bin_sync;

  // ---------------------------------------------------------------------------
  // Write domain
  // ---------------------------------------------------------------------------
  assign w_wr_push     = wr_en && !full;
  assign w_wr_bin_nxt  = r_wr_bin + PtrOne;
  assign w_rd_bin_sync = gray2bin(r_rd_gray_sync[SYNC_STG-1]);

  assign wr_level = r_wr_bin - w_rd_bin_sync;
  assign full     = (wr_level == LvlFull);
  // Level never exceeds DP, so a threshold above DP naturally never fires.
  assign afull    = (wr_level >= wr_afull_th);
  assign overflow = r_overflow;

  // Advance the write pointer and its registered gray copy on an accepted write.
  always_ff @(posedge wr_clk or negedge wr_reset_n) begin
    if (!wr_reset_n) begin
      r_wr_bin  <= '0;
      r_wr_gray <= '0;
    end else if (w_wr_push) begin
      r_wr_bin  <= w_wr_bin_nxt;
      r_wr_gray <= bin2gray(w_wr_bin_nxt);
    end
  end

  // Store accepted write data; writes while full are dropped.
  always_ff @(posedge wr_clk) begin
    if (w_wr_push) begin
      r_mem[r_wr_bin[AW-1:0]] <= wr_data;
    end
  end

  // Sticky overflow: a set in the same cycle as a clear wins.
  always_ff @(posedge wr_clk or negedge wr_reset_n) begin
    if (!wr_reset_n) begin
      r_overflow <= 1'b0;
    end else if (wr_en && full) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  // Bring the read-side gray pointer into wr_clk through the synchroniser chain.
  always_ff @(posedge wr_clk or negedge wr_reset_n) begin
    if (!wr_reset_n) begin
      for (int unsigned i = 0; i < SYNC_STG; i++) begin
        r_rd_gray_sync[i] <= '0;
      end
    end else begin
      r_rd_gray_sync[0] <= r_rd_gray;
      for (int unsigned i = 1; i < SYNC_STG; i++) begin
        r_rd_gray_sync[i] <= r_rd_gray_sync[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read domain
  // ---------------------------------------------------------------------------
  assign w_rd_pop      = rd_en && !empty;
  assign w_rd_bin_nxt  = r_rd_bin + PtrOne;
  assign w_wr_bin_sync = gray2bin(r_wr_gray_sync[SYNC_STG-1]);

  assign rd_level  = w_wr_bin_sync - r_rd_bin;
  assign empty     = (rd_level == '0);
  assign aempty    = (rd_level <= rd_aempty_th);
  assign underflow = r_underflow;
  // Show-ahead head entry; meaningless while empty.
  assign rd_data   = r_mem[r_rd_bin[AW-1:0]];

  // Advance the read pointer and its registered gray copy on an accepted pop.
  always_ff @(posedge rd_clk or negedge rd_reset_n) begin
    if (!rd_reset_n) begin
      r_rd_bin  <= '0;
      r_rd_gray <= '0;
    end else if (w_rd_pop) begin
      r_rd_bin  <= w_rd_bin_nxt;
      r_rd_gray <= bin2gray(w_rd_bin_nxt);
    end
  end

  // Sticky underflow: a set in the same cycle as a clear wins.
  always_ff @(posedge rd_clk or negedge rd_reset_n) begin
    if (!rd_reset_n) begin
      r_underflow <= 1'b0;
    end else if (rd_en && empty) begin
      r_underflow <= 1'b1;
    end else if (udf_clr) begin
      r_underflow <= 1'b0;
    end
  end

  // Bring the write-side gray pointer into rd_clk through the synchroniser chain.
  always_ff @(posedge rd_clk or negedge rd_reset_n) begin
    if (!rd_reset_n) begin
      for (int unsigned i = 0; i < SYNC_STG; i++) begin
        r_wr_gray_sync[i] <= '0;
      end
    end else begin
      r_wr_gray_sync[0] <= r_wr_gray;
      for (int unsigned i = 1; i < SYNC_STG; i++) begin
        r_wr_gray_sync[i] <= r_wr_gray_sync[i-1];
      end
    end
  end

endmodule

// File: doc/async_fifo_lvl.md
Name: async_fifo_lvl

Overview:
- Dual-clock FIFO that succeeds the fixed-flag async FIFO; intended for SPI, UART and wishbone clock-domain crossings where software-visible depth matters.
- Depth is any power of two (2^AW), and the synchroniser stage count is a parameter.
- Adds programmable almost-full/almost-empty thresholds and a fill-level output on each side.
- Adds sticky overflow/underflow error flags with clears. Illegal accesses are blocked rather than stopping simulation.

Parameters:
- W, 8, data width in bits.
- AW, 2, address width; depth DP = 2^AW; legal range 1..10.
- SYNC_STG, 2, number of gray-pointer synchroniser flops per direction; legal range 2..4.

Ports:
- wr_clk  in  1  write clock
- wr_reset_n  in  1  write-domain reset
- wr_en  in  1  write request
- wr_data  in  W  write data
- wr_afull_th  in  AW+1  almost-full threshold (quasi-static)
- ovf_clr  in  1  clear overflow
- full  out  1  FIFO full (wr_clk)
- afull  out  1  wr_level >= wr_afull_th
- wr_level  out  AW+1  occupancy as seen by the write side
- overflow  out  1  sticky write-when-full error
- rd_clk  in  1  read clock
- rd_reset_n  in  1  read-domain reset, asynchronous, active-low
- rd_en  in  1  read request (pop)
- rd_aempty_th  in  AW+1  almost-empty threshold (quasi-static)
- udf_clr  in  1  clear underflow
- rd_data  out  W  head-of-FIFO data (show-ahead)
- empty  out  1  FIFO empty (rd_clk)
- aempty  out  1  rd_level <= rd_aempty_th
- rd_level  out  AW+1  occupancy as seen by the read side
- underflow  out  1  sticky read-when-empty error

Behaviour:
- Reset and clocking: reset wr_reset_n, asynchronous, active-low; clock wr_clk. All write-domain flops use wr_clk/wr_reset_n; all read-domain flops use rd_clk/rd_reset_n.
- Pointers: wr_ptr and rd_ptr are AW+1-bit binary counters. Gray code is gray = b ^ (b>>1), registered in the source domain. The gray pointer passes through SYNC_STG flops in the destination domain and is then converted back to binary. Only registered gray values cross domains.
- Levels:
  - wr_level = wr_ptr - sync_rd_bin, modulo 2^(AW+1); range 0..DP.
  - rd_level = sync_wr_bin - rd_ptr, same arithmetic.
  - Both are combinational from registered pointers.
- Flags:
  - full = (wr_level == DP); empty = (rd_level == 0).
  - afull = (wr_level >= wr_afull_th); a threshold greater than DP means afull never asserts.
  - aempty = (rd_level <= rd_aempty_th).
  - All flags are pessimistic: a peer-side change becomes visible SYNC_STG edges of the local clock after the peer's pointer update.
- Write:
  - wr_en && !full: mem[wr_ptr[AW-1:0]] <= wr_data, and wr_ptr increments, at the same edge.
  - wr_en && full: data is dropped, the pointer holds, and overflow <= 1.
- Read:
  - rd_data = mem[rd_ptr[AW-1:0]] combinationally (zero-latency show-ahead). It is valid whenever empty = 0.
  - rd_en && !empty: rd_ptr increments.
  - rd_en && empty: the pointer holds and underflow <= 1. rd_data is don't-care.
- Sticky errors: overflow is cleared by ovf_clr and underflow by udf_clr. A same-cycle set and clear leaves the flag set.
- Latency:
  - Write at wr_clk edge N: empty falls after SYNC_STG rd_clk edges following that edge (plus up to one rd_clk of phase uncertainty).
  - Pop: full releases after SYNC_STG wr_clk edges.
- Wrap-around: pointers wrap at 2^(AW+1). The extra MSB distinguishes full from empty. Levels must stay correct across any number of wraps.
- Reset values:
  - full = 0, wr_level = 0, overflow = 0, afull = (wr_afull_th == 0).
  - empty = 1, aempty = 1, rd_level = 0, underflow = 0. rd_data is undefined.
  - Memory is not reset.
- Reset mid-operation: wr_reset_n and rd_reset_n must overlap by at least SYNC_STG cycles of the slower clock. Contents are discarded. Reset of one side alone is unsupported, and flags are undefined until both sides are reset.
- Thresholds: changed only while the FIFO is idle. No internal registering.
- Simultaneous read and write: legal at any level. On the full and empty boundaries, each side uses only its own flag.

Test Plan (W=8, AW=2, DP=4, SYNC_STG=2):
- Reset → empty=1, full=0, wr_level=0, rd_level=0, overflow=0, underflow=0.
- Write 0xA1 at wr_clk edge N; hold reads → empty stays 1 until 2 rd_clk edges elapse, then empty=0, rd_data=0xA1, rd_level=1.
- Write 0x10..0x13, then attempt 0x14 → full=1 and wr_level=4 after the fourth write; 0x14 is dropped and overflow=1. Drain yields 0x10, 0x11, 0x12, 0x13. Pulse ovf_clr → overflow=0.
- With wr_afull_th=3 and rd_aempty_th=1, fill to 3 → afull=1. Drain to 1 → aempty=1, and aempty=0 when rd_level=2.
- Pop while empty → rd_ptr unchanged and underflow=1. A same-cycle udf_clr with a second illegal pop → underflow stays 1.
- Stream 40 words with a 100 MHz writer and a 37 MHz reader, throttling on full/empty → in-order data, no overflow or underflow, levels correct across 5 pointer wraps.
- Assert both resets with 3 entries present → empty=1 and all levels 0 after release.
